// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares the UART transmitter between two byte
// sources. It polls the UART status register until the transmitter is idle,
// then writes the granted byte to the TX data register.
module uart_tx_arbiter #(
  parameter logic [1:0]  TX_ADDR     = 2'd0,
  parameter logic [1:0]  STATUS_ADDR = 2'd1,
  parameter int unsigned BUSY_BIT    = 0,
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic [1:0] wb_addr,
  output logic [7:0] wb_data_out,
  input  logic [7:0] wb_data_in,
  output logic       wb_we,
  output logic       wb_stb,
  input  logic       wb_ack,
  output logic [1:0] grant,
  output logic       done,
  output logic       timeout_err
);

  typedef enum logic [1:0] {IDLE, POLL, GAP, WRITE} state_t;

  localparam logic [7:0] LIMIT = 8'(ACK_TIMEOUT);

  state_t     state, state_n;
  logic [7:0] data_n;
  logic [1:0] addr_n;
  logic       stb_n, we_n;
  logic [1:0] grant_n;
  logic       done_n, terr_n;
  logic [7:0] cnt, cnt_n, cnt_inc;
  logic       last, last_n;   // 1 = requester 1 was granted last
  logic       pick1;          // arbitration winner is requester 1
  logic       busy;
  logic       unused_status;  // only BUSY_BIT of the status word matters

  assign busy          = wb_data_in[BUSY_BIT];
  assign unused_status = ^wb_data_in;
  assign cnt_inc       = cnt + 8'd1;

  // Arbitration and combinational ready (only output that is not registered)
  always_comb begin
    pick1      = req1_valid & (~req0_valid | ~last);
    req0_ready = (state == IDLE) & req0_valid & ~pick1;
    req1_ready = (state == IDLE) & pick1;
  end

  // Next-state and next-output logic for the bus sequencer
  always_comb begin
    state_n = state;
    data_n  = wb_data_out;
    addr_n  = wb_addr;
    stb_n   = wb_stb;
    we_n    = wb_we;
    grant_n = grant;
    done_n  = 1'b0;
    terr_n  = 1'b0;
    cnt_n   = cnt;
    last_n  = last;
    case (state)
      IDLE: begin
        if (req0_ready | req1_ready) begin
          data_n  = pick1 ? req1_data : req0_data;
          grant_n = pick1 ? 2'b10 : 2'b01;
          last_n  = pick1;
          state_n = POLL;
          stb_n   = 1'b1;
          we_n    = 1'b0;
          addr_n  = STATUS_ADDR;
          cnt_n   = '0;
        end
      end
      POLL: begin
        if (wb_ack) begin
          if (busy) begin
            state_n = GAP;
            stb_n   = 1'b0;
          end else begin
            // Write cycle starts back-to-back with the status read
            state_n = WRITE;
            stb_n   = 1'b1;
            we_n    = 1'b1;
            addr_n  = TX_ADDR;
            cnt_n   = '0;
          end
        end else if (cnt_inc == LIMIT) begin
          state_n = IDLE;
          stb_n   = 1'b0;
          we_n    = 1'b0;
          terr_n  = 1'b1;
          grant_n = '0;
        end else begin
          cnt_n = cnt_inc;
        end
      end
      GAP: begin
        state_n = POLL;
        stb_n   = 1'b1;
        we_n    = 1'b0;
        addr_n  = STATUS_ADDR;
        cnt_n   = '0;
      end
      WRITE: begin
        if (wb_ack) begin
          state_n = IDLE;
          stb_n   = 1'b0;
          we_n    = 1'b0;
          done_n  = 1'b1;
          grant_n = '0;
        end else if (cnt_inc == LIMIT) begin
          state_n = IDLE;
          stb_n   = 1'b0;
          we_n    = 1'b0;
          terr_n  = 1'b1;
          grant_n = '0;
        end else begin
          cnt_n = cnt_inc;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and registered outputs; reset drops any in-flight cycle silently
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      wb_data_out <= '0;
      wb_addr     <= '0;
      wb_stb      <= 1'b0;
      wb_we       <= 1'b0;
      grant       <= '0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
      cnt         <= '0;
      last        <= 1'b1;
    end else begin
      state       <= state_n;
      wb_data_out <= data_n;
      wb_addr     <= addr_n;
      wb_stb      <= stb_n;
      wb_we       <= we_n;
      grant       <= grant_n;
      done        <= done_n;
      timeout_err <= terr_n;
      cnt         <= cnt_n;
      last        <= last_n;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter with a zero-latency
// UART register model (ack follows stb, status busy for a set poll count).
module tb_uart_tx_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0_valid, req1_valid;
  logic [7:0] req0_data, req1_data;
  logic       req0_ready, req1_ready;
  logic [1:0] wb_addr;
  logic [7:0] wb_data_out, wb_data_in;
  logic       wb_we, wb_stb, wb_ack;
  logic [1:0] grant;
  logic       done, timeout_err;

  int n_checks = 0;
  int n_errors = 0;

  // UART model controls
  int   poll_cnt = 0;
  int   busy_limit = 0;
  logic ack_poll_en = 1'b1;
  logic ack_write_en = 1'b1;
  logic [7:0] wr_data[$];
  logic [1:0] wr_grant[$];

  uart_tx_arbiter #(
    .TX_ADDR(2'd0),
    .STATUS_ADDR(2'd1),
    .BUSY_BIT(0),
    .ACK_TIMEOUT(15)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req0_valid(req0_valid),
    .req0_data(req0_data),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid),
    .req1_data(req1_data),
    .req1_ready(req1_ready),
    .wb_addr(wb_addr),
    .wb_data_out(wb_data_out),
    .wb_data_in(wb_data_in),
    .wb_we(wb_we),
    .wb_stb(wb_stb),
    .wb_ack(wb_ack),
    .grant(grant),
    .done(done),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  assign wb_ack     = wb_stb & (wb_we ? ack_write_en : ack_poll_en);
  assign wb_data_in = (poll_cnt < busy_limit) ? 8'h01 : 8'h00;

  // Record completed status reads and data writes
  always @(posedge clk) begin
    if (wb_stb && wb_ack && !wb_we) poll_cnt <= poll_cnt + 1;
    if (wb_stb && wb_ack && wb_we) begin
      wr_data.push_back(wb_data_out);
      wr_grant.push_back(grant);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One uncontended byte with immediate acks and an idle transmitter
  task automatic send_one(input logic src, input logic [7:0] b, input string tag);
    int base;
    base = wr_data.size();
    if (src) begin req1_valid = 1'b1; req1_data = b; end
    else     begin req0_valid = 1'b1; req0_data = b; end
    #1;
    check({tag, "_ready"}, src ? req1_ready : req0_ready, 1);
    check({tag, "_other_ready"}, src ? req0_ready : req1_ready, 0);
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check({tag, "_c1_poll"}, {wb_stb, wb_we, wb_addr}, {1'b1, 1'b0, 2'd1});
    check({tag, "_c1_grant"}, grant, src ? 2'b10 : 2'b01);
    step();
    check({tag, "_c2_write"}, {wb_stb, wb_we, wb_addr, wb_data_out}, {1'b1, 1'b1, 2'd0, b});
    check({tag, "_c2_grant"}, grant, src ? 2'b10 : 2'b01);
    step();
    check({tag, "_c3_done"}, {done, wb_stb, grant}, {1'b1, 1'b0, 2'b00});
    step();
    check({tag, "_c4_done_low"}, done, 0);
    check({tag, "_nwrites"}, wr_data.size() - base, 1);
    if (wr_data.size() > 0) check({tag, "_wdata"}, wr_data[wr_data.size()-1], b);
  endtask

  initial begin
    logic [5:0] exp_stb;
    logic [5:0] exp_we;
    int base, c0, c1, hi, ndone, nerr, nstb;

    reset = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_data = 8'h00; req1_data = 8'h00;
    step();
    step();
    check("reset_outputs", {wb_stb, wb_we, grant, done, timeout_err, wb_addr, wb_data_out},
          {1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'd0, 8'h00});
    check("reset_ready", {req0_ready, req1_ready}, 2'b00);
    reset = 1'b0;
    step();

    // Single byte from requester 0
    send_one(1'b0, 8'h41, "single");

    // Busy status twice, then idle; requester 1
    busy_limit = poll_cnt + 2;
    base = wr_data.size();
    exp_stb = 6'b110101;   // cycle 1 in bit 0
    exp_we  = 6'b100000;
    req1_valid = 1'b1; req1_data = 8'h55;
    #1;
    check("busy_ready1", req1_ready, 1);
    for (int c = 0; c < 6; c++) begin
      step();
      req1_valid = 1'b0;
      check($sformatf("busy_c%0d_stb_we", c + 1), {wb_stb, wb_we}, {exp_stb[c], exp_we[c]});
    end
    step();
    check("busy_done", {done, grant}, {1'b1, 2'b00});
    step();
    check("busy_nwrites", wr_data.size() - base, 1);
    if (wr_data.size() > base) check("busy_wdata", wr_data[base], 8'h55);

    // Contention: both hold valid for 4 bytes each
    base = wr_data.size();
    c0 = 0; c1 = 0;
    req0_data = 8'h41; req1_data = 8'h42;
    for (int cyc = 0; cyc < 100 && wr_data.size() < base + 8; cyc++) begin
      req0_valid = (c0 < 4);
      req1_valid = (c1 < 4);
      #1;
      if (req0_ready) c0++;
      if (req1_ready) c1++;
      step();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    check("rr_nwrites", wr_data.size() - base, 8);
    if (wr_data.size() >= base + 8) begin
      for (int i = 0; i < 8; i++) begin
        check($sformatf("rr_data%0d", i), wr_data[base + i], (i % 2 == 0) ? 8'h41 : 8'h42);
        check($sformatf("rr_grant%0d", i), wr_grant[base + i], (i % 2 == 0) ? 2'b01 : 2'b10);
      end
    end
    step();
    step();

    // Write never acked: abort after ACK_TIMEOUT stb-high cycles
    ack_write_en = 1'b0;
    req0_valid = 1'b1; req0_data = 8'h77;
    #1;
    check("to_ready0", req0_ready, 1);
    step();
    req0_valid = 1'b0;
    check("to_c1_poll", {wb_stb, wb_we, wb_addr}, {1'b1, 1'b0, 2'd1});
    hi = 0; ndone = 0; nerr = 0;
    for (int k = 2; k <= 16; k++) begin
      step();
      if (wb_stb && wb_we) hi++;
      if (done) ndone++;
      if (timeout_err) nerr++;
    end
    check("to_stb_cycles", hi, 15);
    check("to_err_early", nerr, 0);
    step();
    check("to_c17", {wb_stb, timeout_err, grant}, {1'b0, 1'b1, 2'b00});
    if (done) ndone++;
    step();
    check("to_c18_err_low", timeout_err, 0);
    if (done) ndone++;
    check("to_no_done", ndone, 0);
    ack_write_en = 1'b1;
    send_one(1'b1, 8'h99, "after_to");

    // Reset while polling a permanently busy transmitter
    busy_limit = poll_cnt + 1000;
    req0_valid = 1'b1; req0_data = 8'h12;
    #1;
    check("rst_ready0", req0_ready, 1);
    step();
    req0_valid = 1'b0;
    check("rst_c1_poll", {wb_stb, wb_addr}, {1'b1, 2'd1});
    reset = 1'b1;
    step();
    check("rst_next", {wb_stb, wb_we, grant, done, timeout_err}, {1'b0, 1'b0, 2'b00, 1'b0, 1'b0});
    reset = 1'b0;
    nstb = 0; ndone = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      if (wb_stb) nstb++;
      if (done || timeout_err) ndone++;
    end
    check("rst_quiet_stb", nstb, 0);
    check("rst_quiet_pulse", ndone, 0);
    busy_limit = poll_cnt;
    base = wr_data.size();
    req0_valid = 1'b1; req0_data = 8'h21;
    req1_valid = 1'b1; req1_data = 8'h22;
    #1;
    check("rst_tie_ready", {req0_ready, req1_ready}, 2'b10);
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    check("rst_tie_grant", grant, 2'b01);
    step();
    step();
    check("rst_tie_done", done, 1);
    if (wr_data.size() > base) check("rst_tie_wdata", wr_data[base], 8'h21);
    else check("rst_tie_nwrites", wr_data.size() - base, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
